// File: rtl/rsp_buf2.sv
// Two-entry in-order skid buffer for read responses; data is held stable
// while out_valid_o is high and out_ready_i is low.
module rsp_buf2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  logic [1:0][WIDTH-1:0] mem;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  push, pop;

  assign in_ready_o  = (count != 2'd2);
  assign out_valid_o = (count != 2'd0);
  assign out_data_o  = mem[rd_ptr];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sp_ram_be.sv
// Single-port byte-enable RAM; read data optionally registered (OUT_REG).
module sp_ram_be #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH/8-1:0]       wr_byte_en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  localparam int BE_W = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++)
        if (wr_byte_en_i[b]) mem[addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
    end
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk_i) if (rd_en_i) rd_q <= mem[addr_i];
    assign rd_data_o = rd_q;
  end else begin : g_comb
    assign rd_data_o = mem[addr_i];
  end
endmodule

// File: rtl/mem_port_ctrl.sv
// Valid/ready request port in front of a single-port RAM. Reads are credited
// (max 2 in flight + buffered) so the response buffer can never overflow.
module mem_port_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_wr_i,
  input  logic [WIDTH/8-1:0]       req_byte_en_i,
  input  logic [$clog2(DEPTH)-1:0] req_addr_i,
  input  logic [WIDTH-1:0]         req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic                     ram_wr_en_o,
  output logic [WIDTH/8-1:0]       ram_wr_byte_en_o,
  output logic [$clog2(DEPTH)-1:0] ram_rw_addr_o,
  output logic [WIDTH-1:0]         ram_rw_data_o,
  output logic                     ram_rd_en_o,
  input  logic [WIDTH-1:0]         ram_rd_data_i
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BE_W = WIDTH / 8;

  logic [1:0] cnt;
  logic       accept, rd_acc, rsp_hs;
  logic       push_vld, push_rdy;

  assign req_ready_o = (cnt < 2'd2);
  assign accept      = req_valid_i & req_ready_o;
  assign rd_acc      = accept & ~req_wr_i;
  assign rsp_hs      = rsp_valid_o & rsp_ready_i;

  assign ram_rw_addr_o    = req_addr_i[AW-1:0];
  assign ram_rw_data_o    = req_data_i;
  assign ram_wr_byte_en_o = req_byte_en_i[BE_W-1:0];
  assign ram_wr_en_o      = accept & req_wr_i;
  assign ram_rd_en_o      = rd_acc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt <= 2'd0;
    else case ({rd_acc, rsp_hs})
      2'b10:   cnt <= cnt + 2'd1;
      2'b01:   cnt <= cnt - 2'd1;
      default: cnt <= cnt;
    endcase
  end

  // Registered RAM returns data one cycle after the accept; track it with pend.
  if (OUT_REG) begin : g_pend
    logic pend;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) pend <= 1'b0;
      else          pend <= rd_acc;
    end
    assign push_vld = pend;
  end else begin : g_nopend
    assign push_vld = rd_acc;
  end

  rsp_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_valid_i (push_vld),
    .in_ready_o (push_rdy),
    .in_data_i  (ram_rd_data_i),
    .out_valid_o(rsp_valid_o),
    .out_ready_i(rsp_ready_i),
    .out_data_o (rsp_data_o)
  );

  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_n_i) cnt <= 2'd2);
  a_buf_ovf:   assert property (@(posedge clk_i) disable iff (!rst_n_i) push_vld |-> push_rdy);
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench: registered-RAM instance (u_dut) checked throughout, and a
// combinational-RAM instance (u_dut_c) sharing stimulus for the latency case.
module tb_mem_port_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int BW    = 4;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             req_valid_i = 1'b0, req_wr_i = 1'b0, rsp_ready_i = 1'b0;
  logic [BW-1:0]    req_byte_en_i = '0;
  logic [AW-1:0]    req_addr_i = '0;
  logic [WIDTH-1:0] req_data_i = '0;

  logic             req_ready_o, rsp_valid_o, ram_wr_en_o, ram_rd_en_o;
  logic [WIDTH-1:0] rsp_data_o, ram_rw_data_o, ram_rd_data_i;
  logic [BW-1:0]    ram_wr_byte_en_o;
  logic [AW-1:0]    ram_rw_addr_o;

  logic             req_ready_c, rsp_valid_c, ram_wr_en_c, ram_rd_en_c;
  logic [WIDTH-1:0] rsp_data_c, ram_rw_data_c, ram_rd_data_c;
  logic [BW-1:0]    ram_wr_byte_en_c;
  logic [AW-1:0]    ram_rw_addr_c;

  int checks = 0;
  int failures = 0;

  mem_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1'b1)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_byte_en_i(req_byte_en_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_byte_en_o(ram_wr_byte_en_o),
    .ram_rw_addr_o(ram_rw_addr_o), .ram_rw_data_o(ram_rw_data_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_data_i(ram_rd_data_i)
  );
  sp_ram_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1'b1)) u_ram (
    .clk_i(clk_i), .wr_en_i(ram_wr_en_o), .wr_byte_en_i(ram_wr_byte_en_o),
    .addr_i(ram_rw_addr_o), .wr_data_i(ram_rw_data_o), .rd_en_i(ram_rd_en_o),
    .rd_data_o(ram_rd_data_i)
  );

  mem_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1'b0)) u_dut_c (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_c), .req_wr_i(req_wr_i),
    .req_byte_en_i(req_byte_en_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_c), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_c),
    .ram_wr_en_o(ram_wr_en_c), .ram_wr_byte_en_o(ram_wr_byte_en_c),
    .ram_rw_addr_o(ram_rw_addr_c), .ram_rw_data_o(ram_rw_data_c),
    .ram_rd_en_o(ram_rd_en_c), .ram_rd_data_i(ram_rd_data_c)
  );
  sp_ram_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_REG(1'b0)) u_ram_c (
    .clk_i(clk_i), .wr_en_i(ram_wr_en_c), .wr_byte_en_i(ram_wr_byte_en_c),
    .addr_i(ram_rw_addr_c), .wr_data_i(ram_rw_data_c), .rd_en_i(ram_rd_en_c),
    .rd_data_o(ram_rd_data_c)
  );

  task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a,
                       input logic [WIDTH-1:0] d, input logic [BW-1:0] be);
    req_valid_i = v; req_wr_i = wr; req_addr_i = a; req_data_i = d; req_byte_en_i = be;
  endtask

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Pops one response (rsp_ready_i must be high); ok=0 if none within 20 cycles.
  task automatic wait_rsp(output logic [WIDTH-1:0] d, output bit ok);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid_o && rsp_ready_i) begin d = rsp_data_o; ok = 1'b1; end
      tick();
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
    checks++; if (rsp_data_o !== 32'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data_o); end
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_o); end
    checks++; if ({ram_wr_en_o, ram_rd_en_o} !== 2'b00) begin failures++; $display("FAIL reset_ram_idle got=%b exp=00", {ram_wr_en_o, ram_rd_en_o}); end
    drive(1'b1, 1'b1, 8'h3F, 32'h0, 4'hF); #1;
    checks++; if ({ram_wr_en_o, ram_rd_en_o} !== 2'b10) begin failures++; $display("FAIL reset_comb_wr got=%b exp=10", {ram_wr_en_o, ram_rd_en_o}); end
    req_wr_i = 1'b0; #1;
    checks++; if ({ram_wr_en_o, ram_rd_en_o} !== 2'b01) begin failures++; $display("FAIL reset_comb_rd got=%b exp=01", {ram_wr_en_o, ram_rd_en_o}); end
    idle();
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF); #1;
    checks++; if ({ram_wr_en_o, ram_rd_en_o, ram_rw_addr_o, ram_wr_byte_en_o} !== {2'b10, 8'h05, 4'hF})
      begin failures++; $display("FAIL wr_ctrl got=%b_%h_%h exp=10_05_f", {ram_wr_en_o, ram_rd_en_o}, ram_rw_addr_o, ram_wr_byte_en_o); end
    checks++; if (ram_rw_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data got=%h exp=deadbeef", ram_rw_data_o); end
    tick(); idle(); #1;
    checks++; if ({ram_wr_en_o, ram_rd_en_o} !== 2'b00) begin failures++; $display("FAIL idle_ram got=%b exp=00", {ram_wr_en_o, ram_rd_en_o}); end
    drive(1'b1, 1'b0, 8'h05, '0, '0); #1;
    checks++; if ({ram_wr_en_o, ram_rd_en_o} !== 2'b01) begin failures++; $display("FAIL rd_ctrl got=%b exp=01", {ram_wr_en_o, ram_rd_en_o}); end
    tick(); idle();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL lat_reg_early got=%b exp=0", rsp_valid_o); end
    checks++; if ({rsp_valid_c, rsp_data_c} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL lat_comb got=%b_%h exp=1_deadbeef", rsp_valid_c, rsp_data_c); end
    tick();
    checks++; if ({rsp_valid_o, rsp_data_o} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL lat_reg got=%b_%h exp=1_deadbeef", rsp_valid_o, rsp_data_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL single_rsp got=%b exp=0", rsp_valid_o); end
  endtask

  task automatic test_byte_en;
    logic [WIDTH-1:0] d; bit ok;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 8'h07, 32'h11223344, 4'hF); tick();
    drive(1'b1, 1'b1, 8'h07, 32'hAAAAAAAA, 4'b0010); tick();
    drive(1'b1, 1'b0, 8'h07, '0, '0); tick(); idle();
    wait_rsp(d, ok);
    checks++; if (!ok || d !== 32'h1122AA44) begin failures++; $display("FAIL byte_en got=%h ok=%0d exp=1122aa44", d, ok); end
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] d1, d2; bit ok1, ok2; int acc, seen;
    rsp_ready_i = 1'b0; acc = 0; seen = 0;
    drive(1'b1, 1'b0, 8'h05, '0, '0); #1; if (req_ready_o) acc++; tick();
    drive(1'b1, 1'b0, 8'h07, '0, '0); #1; if (req_ready_o) acc++; tick();
    drive(1'b1, 1'b0, 8'h00, '0, '0); #1; if (req_ready_o) acc++;
    checks++; if ({req_ready_o, ram_rd_en_o} !== 2'b00) begin failures++; $display("FAIL bp_stall got=%b exp=00", {req_ready_o, ram_rd_en_o}); end
    tick(); idle();
    checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", acc); end
    tick(); tick(); tick();
    checks++; if ({rsp_valid_o, rsp_data_o, req_ready_o} !== {1'b1, 32'hDEADBEEF, 1'b0})
      begin failures++; $display("FAIL bp_hold got=%b_%h_%b exp=1_deadbeef_0", rsp_valid_o, rsp_data_o, req_ready_o); end
    rsp_ready_i = 1'b1;
    wait_rsp(d1, ok1);
    wait_rsp(d2, ok2);
    checks++; if (!ok1 || d1 !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_rsp0 got=%h ok=%0d exp=deadbeef", d1, ok1); end
    checks++; if (!ok2 || d2 !== 32'h1122AA44) begin failures++; $display("FAIL bp_rsp1 got=%h ok=%0d exp=1122aa44", d2, ok2); end
    for (int i = 0; i < 3; i++) begin if (rsp_valid_o) seen++; tick(); end
    checks++; if (seen !== 0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_drain extra=%0d ready=%b exp=0,1", seen, req_ready_o); end
  endtask

  task automatic test_full_handshake;
    logic [WIDTH-1:0] d; bit ok; int seen;
    rsp_ready_i = 1'b0; seen = 0;
    drive(1'b1, 1'b0, 8'h05, '0, '0); tick();
    drive(1'b1, 1'b0, 8'h07, '0, '0); tick(); idle();
    tick(); tick();
    checks++; if ({req_ready_o, rsp_valid_o} !== 2'b01) begin failures++; $display("FAIL full_state got=%b exp=01", {req_ready_o, rsp_valid_o}); end
    drive(1'b1, 1'b0, 8'h10, '0, '0); rsp_ready_i = 1'b1; #1;
    checks++; if ({req_ready_o, ram_rd_en_o} !== 2'b00) begin failures++; $display("FAIL full_no_accept got=%b exp=00", {req_ready_o, ram_rd_en_o}); end
    tick(); idle(); rsp_ready_i = 1'b0;
    checks++; if ({req_ready_o, rsp_valid_o, rsp_data_o} !== {2'b11, 32'h1122AA44})
      begin failures++; $display("FAIL full_after got=%b_%b_%h exp=1_1_1122aa44", req_ready_o, rsp_valid_o, rsp_data_o); end
    rsp_ready_i = 1'b1;
    wait_rsp(d, ok);
    for (int i = 0; i < 4; i++) begin if (rsp_valid_o) seen++; tick(); end
    checks++; if (!ok || seen !== 0) begin failures++; $display("FAIL full_drain ok=%0d extra=%0d exp=1,0", ok, seen); end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] d; bit ok; int seen;
    rsp_ready_i = 1'b0; seen = 0;
    drive(1'b1, 1'b0, 8'h05, '0, '0); tick();
    drive(1'b1, 1'b0, 8'h07, '0, '0); tick(); idle();
    checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", rsp_valid_o); end
    rst_n_i = 1'b0; #1;
    checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin failures++; $display("FAIL rst_mid_now got=%b exp=01", {rsp_valid_o, req_ready_o}); end
    tick(); rst_n_i = 1'b1; rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid_o) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_silent got=%0d exp=0", seen); end
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b0, 8'h05, '0, '0); tick(); idle();
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_cnt got=%b exp=1", req_ready_o); end
    rsp_ready_i = 1'b1;
    wait_rsp(d, ok);
    checks++; if (!ok || d !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_mid_rsp got=%h ok=%0d exp=deadbeef", d, ok); end
  endtask

  task automatic test_wr_rd_back_to_back;
    logic [WIDTH-1:0] d; bit ok;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 8'h10, 32'h01010101, 4'hF); tick();
    drive(1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 4'hF); tick();
    drive(1'b1, 1'b0, 8'h10, '0, '0); tick(); idle();
    wait_rsp(d, ok);
    checks++; if (!ok || d !== 32'hCAFEF00D) begin failures++; $display("FAIL wr_rd_b2b got=%h ok=%0d exp=cafef00d", d, ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_en();
    test_backpressure();
    test_full_handshake();
    test_reset_mid();
    test_wr_rd_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
